// File: rtl/conv_encoder_k3_if.sv
// Handshake bundle between a bit source, the K=3 convolutional encoder and
// the symbol sink. The encoder connects through the slave modport.
interface conv_encoder_k3_if;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] enc_pair;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output in_bit, in_valid, out_ready,
    input  in_ready, enc_pair, out_valid, out_last
  );

  modport slave (
    input  in_bit, in_valid, out_ready,
    output in_ready, enc_pair, out_valid, out_last
  );
endinterface

// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder with two zero tail bits per frame and
// a single output holding register behind valid/ready handshakes.
module conv_encoder_k3 #(
  parameter int unsigned FRAME_LEN = 8,
  parameter logic [2:0]  G0        = 3'b111,
  parameter logic [2:0]  G1        = 3'b101
) (
  input  logic            clk,
  input  logic            rst_n,
  conv_encoder_k3_if.slave bus,
  output logic            busy
);

  localparam int unsigned CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {DATA, TAIL, DONE} state_e;

  state_e        state_q;
  logic [1:0]    sr_q;
  logic [CW-1:0] bit_cnt_q;
  logic          tail_cnt_q;
  logic [1:0]    pair_q;
  logic          valid_q;
  logic          last_q;
  logic          busy_q;

  logic slot_free;
  logic accept;
  logic consume;

  // Tap vector is {current bit, sr[0], sr[1]} to match generator bits [2:0].
  function automatic logic [1:0] encode(input logic d, input logic [1:0] sr);
    logic [2:0] taps;
    taps = {d, sr[0], sr[1]};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

  assign slot_free    = !valid_q || bus.out_ready;
  assign bus.in_ready = (state_q == DATA) && slot_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign consume      = valid_q && bus.out_ready;

  assign bus.enc_pair  = pair_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign busy          = busy_q;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; a later load in the same block overrides the consume clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DATA;
      sr_q       <= 2'b00;
      bit_cnt_q  <= '0;
      tail_cnt_q <= 1'b0;
      pair_q     <= 2'b00;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (consume) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end

      unique case (state_q)
        DATA: begin
          if (accept) begin
            pair_q  <= encode(bus.in_bit, sr_q);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            sr_q    <= {sr_q[0], bus.in_bit};
            if (bit_cnt_q == CW'(FRAME_LEN - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= TAIL;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end

        TAIL: begin
          if (slot_free) begin
            pair_q     <= encode(1'b0, sr_q);
            valid_q    <= 1'b1;
            sr_q       <= {sr_q[0], 1'b0};
            tail_cnt_q <= ~tail_cnt_q;
            if (tail_cnt_q) begin
              last_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end

        DONE: begin
          if (consume && last_q) begin
            busy_q  <= 1'b0;
            sr_q    <= 2'b00;
            state_q <= DATA;
          end
        end

        default: state_q <= DATA;
      endcase
    end
  end

endmodule

// File: doc/conv_encoder_k3.md
Name: conv_encoder_k3

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder: the transmit-side counterpart of the Viterbi decoder's branch-metric and ACS path.
- Accepts a serial data-bit stream and emits one 2-bit code symbol per data bit, in the same bit ordering the decoder's received-pair input expects.
- Frames are FRAME_LEN data bits, each followed by K-1=2 zero tail bits so the decoder trellis terminates in state 0.
- Valid/ready handshakes on both sides, with a single output holding register.

Parameters:
- FRAME_LEN, 8, data bits per frame (>=1); tail bits are not counted.
- G0, 3'b111, generator polynomial for enc_pair[1]; bit 2 taps the current bit, bit 1 taps sr[0], bit 0 taps sr[1].
- G1, 3'b101, generator polynomial for enc_pair[0]; same tap mapping as G0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_bit  input  1  data bit.
- in_valid  input  1  in_bit is valid.
- in_ready  output  1  encoder accepts in_bit this cycle.
- enc_pair  output  2  code symbol; [1] = G0 parity, [0] = G1 parity.
- out_valid  output  1  enc_pair is valid.
- out_ready  input  1  downstream consumes enc_pair this cycle.
- out_last  output  1  qualifies the final (second tail) symbol of a frame.
- busy  output  1  high from the first accepted bit of a frame until its out_last symbol is consumed.

Behaviour:
- Reset (async assert, sync release) sets:
  - state=DATA, shift register sr[1:0]=0, bit counter=0, tail counter=0;
  - out_valid=0, enc_pair=0, out_last=0, busy=0.
  - in_ready follows from these values (1 after reset).
- Reset asserted mid-frame aborts the frame:
  - the partial frame is discarded and no out_last is produced;
  - the next accepted bit starts a fresh frame with sr=0.
- Output register rule: "slot free" = !out_valid || out_ready.
- Parity computation for an input bit d:
  - p0 = d&G0[2] ^ sr[0]&G0[1] ^ sr[1]&G0[0];
  - p1 = the same with G1;
  - then sr <= {sr[0], d}.
- FSM states:
  - DATA:
    - in_ready = slot free.
    - On an in_valid && in_ready handshake: load enc_pair={p0,p1} for d=in_bit, set out_valid=1, set busy=1, increment the bit counter.
    - When the handshake is for bit FRAME_LEN: clear the counter and go to TAIL.
  - TAIL:
    - in_ready=0.
    - Each cycle the slot is free: encode d=0, load enc_pair, set out_valid=1.
    - On the second tail symbol also set out_last=1 and go to DONE.
  - DONE:
    - in_ready=0.
    - Wait until the out_last symbol is consumed (out_valid && out_ready && out_last).
    - On that cycle: out_valid drops unless reloaded, busy=0, sr=0 (already 0 by construction, but cleared explicitly), return to DATA.
- Latency: symbol appears on enc_pair/out_valid the cycle after the input handshake (1 clk).
- Throughput: 1 symbol/clk with out_ready held high.
  - Frame cost: FRAME_LEN+2 symbol cycles plus 1 DONE cycle.
  - No input is accepted in the cycle the last symbol is consumed; in_ready returns the following cycle.
- Backpressure: while out_valid && !out_ready:
  - enc_pair, out_last, sr and the counters hold;
  - in_ready=0;
  - no tail advance.
- in_valid while in_ready=0 is ignored; in_bit is not sampled.
- out_last is high only together with out_valid on the second tail symbol; otherwise 0.
- The bit counter is $clog2(FRAME_LEN+1) bits wide and never wraps past FRAME_LEN.

Test Plan:
1. Reset-state check: assert rst_n=0 asynchronously mid-cycle -> out_valid=0, enc_pair=2'b00, out_last=0, busy=0 immediately; in_ready=1 after release.
2. Basic frame, FRAME_LEN=8, out_ready=1: feed 1,0,1,1,0,0,0,0 back-to-back.
   - Expect 10 symbols: 11,10,00,01,01,11,00,00,00,00.
   - out_last only on the 10th; busy falls after it.
3. All-ones frame: feed eight 1s.
   - Expect 11,01,10,10,10,10,10,10, then tail 01,11.
   - out_last on the 11 tail symbol.
4. Backpressure: during frame 2, drop out_ready for 3 cycles at symbol 4 and again on the last tail symbol.
   - enc_pair/out_last stay stable and in_ready=0 throughout each stall.
   - Symbol sequence is identical to frame 2 with no loss or duplication.
5. Reset mid-frame: accept 5 bits, pulse rst_n low, then send frame 2's stimulus.
   - Output must exactly match frame 2's expected sequence (sr cleared, counter restarted).
6. Back-to-back frames with random in_valid gaps and random out_ready.
   - Reference model: software shift-register encoder.
   - Check zero mismatches over 200 frames; exactly one out_last per frame; in_ready=0 during TAIL/DONE.
